// File: rtl/envelope_follower.sv
// Amplitude envelope follower: rectifies a stereo pair, takes the peak and
// tracks it with attack / hold / release ballistics. Two-stage pipeline:
// stage 1 registers the rectified peak, stage 2 updates the envelope.
module envelope_follower #(
    parameter int unsigned ATTACK_SHIFT  = 4,
    parameter int unsigned RELEASE_SHIFT = 10,
    parameter int unsigned HOLD_SAMPLES  = 480
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] leftSampleIn,
    input  logic [15:0] rightSampleIn,
    input  logic        sampleValid,
    output logic [15:0] envelopeOut,
    output logic [7:0]  levelOut,
    output logic        envValid,
    output logic [1:0]  stateOut
);

    typedef enum logic [1:0] {
        StRelease = 2'd0,
        StAttack  = 2'd1,
        StHold    = 2'd2
    } state_e;

    localparam logic [15:0] HoldInit = 16'(HOLD_SAMPLES);

    // Stage 1 registers
    logic [15:0] r_peak;
    logic        r_s1_valid;

    // Stage 2 registers
    logic [15:0] r_env;
    logic [15:0] r_hold;
    logic        r_env_valid;
    state_e      r_state;

    // Combinational helpers
    logic [15:0] w_abs_l;
    logic [15:0] w_abs_r;
    logic [15:0] w_peak;
    logic [15:0] w_diff_up;
    logic [15:0] w_diff_dn;
    logic [15:0] w_att_step;
    logic [15:0] w_rel_step;

    // Rectify and peak-combine; two's-complement negate of 0x8000 yields
    // 0x8000, which read as unsigned is exactly 32768.
    always_comb begin
        w_abs_l = leftSampleIn[15] ? (~leftSampleIn + 16'd1) : leftSampleIn;
        w_abs_r = rightSampleIn[15] ? (~rightSampleIn + 16'd1) : rightSampleIn;
        w_peak  = (w_abs_l > w_abs_r) ? w_abs_l : w_abs_r;
    end

    // Ballistic step sizes, each with a minimum of 1 so the envelope converges
    always_comb begin
        w_diff_up  = r_peak - r_env;
        w_diff_dn  = r_env - r_peak;
        w_att_step = w_diff_up >> ATTACK_SHIFT;
        w_rel_step = w_diff_dn >> RELEASE_SHIFT;
        if (w_att_step == 16'd0) begin
            w_att_step = 16'd1;
        end
        if (w_rel_step == 16'd0) begin
            w_rel_step = 16'd1;
        end
    end

    // Stage 1: capture the peak of each accepted pair
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_peak     <= 16'd0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= sampleValid;
            if (sampleValid) begin
                r_peak <= w_peak;
            end
        end
    end

    // Stage 2: attack / hold / release state update
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_env       <= 16'd0;
            r_hold      <= 16'd0;
            r_env_valid <= 1'b0;
            r_state     <= StRelease;
        end else begin
            r_env_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_peak > r_env) begin
                    r_env   <= r_env + w_att_step;
                    r_hold  <= HoldInit;
                    r_state <= StAttack;
                end else if (r_hold != 16'd0) begin
                    r_hold  <= r_hold - 16'd1;
                    r_state <= StHold;
                end else begin
                    // peak == env leaves env untouched
                    if (r_peak < r_env) begin
                        r_env <= r_env - w_rel_step;
                    end
                    r_state <= StRelease;
                end
            end
        end
    end

    assign envelopeOut = r_env;
    assign levelOut    = r_env[15:8];
    assign envValid    = r_env_valid;
    assign stateOut    = r_state;

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower: one DUT with default ballistics and
// one with a 3-sample hold, both fed from the same stimulus.
module tb_envelope_follower;

    logic        clk;
    logic        rst_n;
    logic [15:0] left;
    logic [15:0] right;
    logic        sample_valid;

    logic [15:0] a_env;
    logic [7:0]  a_lvl;
    logic        a_vld;
    logic [1:0]  a_st;

    logic [15:0] h_env;
    logic [7:0]  h_lvl;
    logic        h_vld;
    logic [1:0]  h_st;

    int checks;
    int failures;

    envelope_follower u_dut_a (
        .CLK           (clk),
        .RST_N         (rst_n),
        .leftSampleIn  (left),
        .rightSampleIn (right),
        .sampleValid   (sample_valid),
        .envelopeOut   (a_env),
        .levelOut      (a_lvl),
        .envValid      (a_vld),
        .stateOut      (a_st)
    );

    envelope_follower #(
        .HOLD_SAMPLES (3)
    ) u_dut_h (
        .CLK           (clk),
        .RST_N         (rst_n),
        .leftSampleIn  (left),
        .rightSampleIn (right),
        .sampleValid   (sample_valid),
        .envelopeOut   (h_env),
        .levelOut      (h_lvl),
        .envValid      (h_vld),
        .stateOut      (h_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset for one cycle; release lands just after a rising edge
    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Strobe one pair and advance to cycle N+2 where the result is visible
    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        left = l;
        right = r;
        sample_valid = 1'b1;
        next_cycle();
        sample_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            left = 16'd1234;
            right = 16'hF000;
            sample_valid = i[0];
            next_cycle();
            checks++;
            if ({a_env, a_lvl, a_vld, a_st} !== 27'd0) begin
                failures++;
                $display("FAIL reset_a got env=%0d lvl=%0d vld=%0b st=%0d want all 0",
                         a_env, a_lvl, a_vld, a_st);
            end
            checks++;
            if ({h_env, h_lvl, h_vld, h_st} !== 27'd0) begin
                failures++;
                $display("FAIL reset_h got env=%0d lvl=%0d vld=%0b st=%0d want all 0",
                         h_env, h_lvl, h_vld, h_st);
            end
        end
        sample_valid = 1'b0;
        rst_n = 1'b1;
        strobe(16'd0, 16'd0);
        checks++;
        if (a_vld !== 1'b1 || a_env !== 16'd0 || a_st !== 2'd0) begin
            failures++;
            $display("FAIL reset_zero_strobe got vld=%0b env=%0d st=%0d want 1 0 0",
                     a_vld, a_env, a_st);
        end
    endtask

    task automatic test_attack();
        left = 16'd16000;
        right = -16'sd100;
        sample_valid = 1'b1;
        next_cycle();
        sample_valid = 1'b0;
        checks++;
        if (a_vld !== 1'b0) begin
            failures++;
            $display("FAIL attack_early_valid got vld=%0b want 0 at N+1", a_vld);
        end
        next_cycle();
        checks++;
        if (a_vld !== 1'b1 || a_env !== 16'd1000 || a_lvl !== 8'd3 || a_st !== 2'd1) begin
            failures++;
            $display("FAIL attack got vld=%0b env=%0d lvl=%0d st=%0d want 1 1000 3 1",
                     a_vld, a_env, a_lvl, a_st);
        end
        next_cycle();
        checks++;
        if (a_vld !== 1'b0 || a_env !== 16'd1000) begin
            failures++;
            $display("FAIL attack_pulse got vld=%0b env=%0d want 0 1000", a_vld, a_env);
        end
    endtask

    task automatic test_hold_release();
        logic [15:0] want_chain [15];
        want_chain = '{16'd2048, 16'd3968, 16'd5768, 16'd7455, 16'd9037,
                       16'd10520, 16'd11910, 16'd13213, 16'd14435, 16'd15580,
                       16'd16654, 16'd17661, 16'd18605, 16'd19490, 16'd20319};
        // Envelope is 1000 from the attack test; hold counter is 3
        for (int i = 0; i < 4; i++) begin
            strobe(16'd0, 16'd0);
            checks++;
            if (i < 3) begin
                if (h_env !== 16'd1000 || h_st !== 2'd2 || h_vld !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_%0d got env=%0d st=%0d vld=%0b want 1000 2 1",
                             i, h_env, h_st, h_vld);
                end
            end else begin
                if (h_env !== 16'd999 || h_st !== 2'd0 || h_vld !== 1'b1) begin
                    failures++;
                    $display("FAIL release_min_step got env=%0d st=%0d vld=%0b want 999 0 1",
                             h_env, h_st, h_vld);
                end
            end
        end
        checks++;
        if (a_env !== 16'd1000 || a_st !== 2'd2) begin
            failures++;
            $display("FAIL long_hold got env=%0d st=%0d want 1000 2", a_env, a_st);
        end
        // Walk the envelope to exactly 20480 through a chain of attacks
        do_reset();
        for (int i = 0; i < 15; i++) begin
            strobe(16'h8000, 16'd0);
            checks++;
            if (h_env !== want_chain[i]) begin
                failures++;
                $display("FAIL attack_chain_%0d got env=%0d want %0d", i, h_env, want_chain[i]);
            end
        end
        strobe(16'd22895, 16'd0);
        checks++;
        if (h_env !== 16'd20480 || h_st !== 2'd1) begin
            failures++;
            $display("FAIL attack_to_20480 got env=%0d st=%0d want 20480 1", h_env, h_st);
        end
        for (int i = 0; i < 3; i++) begin
            strobe(16'd0, 16'd0);
        end
        checks++;
        if (h_env !== 16'd20480 || h_st !== 2'd2) begin
            failures++;
            $display("FAIL hold_20480 got env=%0d st=%0d want 20480 2", h_env, h_st);
        end
        strobe(16'd0, 16'd0);
        checks++;
        if (h_env !== 16'd20460 || h_st !== 2'd0) begin
            failures++;
            $display("FAIL release_20480 got env=%0d st=%0d want 20460 0", h_env, h_st);
        end
    endtask

    task automatic test_rectify_edge();
        logic [15:0] prev;
        bit          reached;
        do_reset();
        prev = 16'd0;
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            strobe(16'h8000, 16'd0);
            checks++;
            if (a_env < prev || a_env > 16'd32768 || a_vld !== 1'b1) begin
                failures++;
                $display("FAIL rectify_step_%0d got env=%0d vld=%0b want >=%0d <=32768 vld 1",
                         i, a_env, a_vld, prev);
            end
            prev = a_env;
            reached = (a_env == 16'd32768);
        end
        checks++;
        if (a_env !== 16'd32768 || a_lvl !== 8'd128) begin
            failures++;
            $display("FAIL rectify_converge got env=%0d lvl=%0d want 32768 128", a_env, a_lvl);
        end
        strobe(16'h8000, 16'h8000);
        checks++;
        if (a_env !== 16'd32768 || a_st !== 2'd2) begin
            failures++;
            $display("FAIL rectify_at_top got env=%0d st=%0d want 32768 2", a_env, a_st);
        end
    endtask

    task automatic test_back_to_back();
        int model_env;
        int step;
        do_reset();
        model_env = 0;
        left = 16'd32767;
        right = 16'd0;
        for (int c = 0; c < 10; c++) begin
            sample_valid = (c < 8);
            next_cycle();
            checks++;
            if (c >= 1 && c <= 8) begin
                step = (32767 - model_env) >>> 4;
                if (step == 0) step = 1;
                model_env = model_env + step;
                if (a_vld !== 1'b1 || a_env !== 16'(model_env)) begin
                    failures++;
                    $display("FAIL b2b_%0d got vld=%0b env=%0d want 1 %0d",
                             c, a_vld, a_env, model_env);
                end
            end else begin
                if (a_vld !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_idle_%0d got vld=%0b want 0", c, a_vld);
                end
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        left = 16'd8000;
        right = 16'd0;
        sample_valid = 1'b1;
        next_cycle();
        sample_valid = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            checks++;
            if (a_vld !== 1'b0 || a_env !== 16'd0 || h_vld !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_%0d got vld=%0b env=%0d hvld=%0b want 0 0 0",
                         i, a_vld, a_env, h_vld);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        left = 16'd0;
        right = 16'd0;
        sample_valid = 1'b0;
        test_reset();
        test_attack();
        test_hold_release();
        test_rectify_edge();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
